// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: shares one external combinational 32-bit ALU between
// NUM_REQ requesters. A round-robin arbiter picks one request, the operands
// are registered onto the ALU port, and the result and ZCNV flags come back
// over a valid/ready response channel tagged with the requester index.
module alu_rr_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*4-1:0]  req_op,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [3:0]            alu_G_sel,
    output logic [31:0]           alu_A,
    output logic [31:0]           alu_B,
    input  logic [31:0]           alu_G,
    input  logic [3:0]            alu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [ID_W:0]   cand;

    // Op codes the ALU actually implements; anything else is answered with rsp_err.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b0110, 4'b1000, 4'b1100, 4'b1110: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Accept strobe to the winner, only while idle and never during reset.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sequencer FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            alu_G_sel <= '0;
            alu_A     <= '0;
            alu_B     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_G_sel <= req_op[grant_idx*4 +: 4];
                        alu_A     <= req_a[grant_idx*32 +: 32];
                        alu_B     <= req_b[grant_idx*32 +: 32];
                        id_q      <= grant_idx;
                        rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    if (op_legal(alu_G_sel)) begin
                        rsp_data  <= alu_G;
                        rsp_flags <= alu_flags;
                        rsp_err   <= 1'b0;
                    end else begin
                        rsp_data  <= '0;
                        rsp_flags <= '0;
                        rsp_err   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
